// File: rtl/sprite_multi_src.sv
// Multi-channel sprite compositor: per-sprite pattern RAMs, origin/ctrl/colour registers,
// frame-tick animation dividers, and a two-stage region/palette/priority pipeline.
module sprite_multi_src #(
  parameter int unsigned   CD        = 12,
  parameter int unsigned   N_SPR     = 4,
  parameter int unsigned   SZ_LOG2   = 4,
  parameter int unsigned   NF_LOG2   = 2,
  parameter logic [CD-1:0] KEY_COLOR = '0,
  localparam int unsigned  AW        = $clog2(N_SPR) + NF_LOG2 + 2*SZ_LOG2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [10:0]   x,
  input  logic [10:0]   y,
  input  logic          wr_en,
  input  logic          wr_ram,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  output logic [CD-1:0] sprite_rgb,
  output logic          hit
);

  localparam int unsigned IW    = (N_SPR > 1) ? $clog2(N_SPR) : 1;
  localparam int unsigned PW    = NF_LOG2 + 2*SZ_LOG2;
  localparam int unsigned DEPTH = 1 << PW;

  // MSB-align a 12-bit palette constant to CD bits
  function automatic logic [CD-1:0] scale12(input logic [11:0] v);
    logic [CD+11:0] t;
    t = {v, CD'(0)};
    return t[CD+11 -: CD];
  endfunction

  function automatic logic [CD-1:0] body_color(input logic [1:0] sel, input logic [CD-1:0] custom);
    logic [CD-1:0] c;
    case (sel)
      2'd0:    c = scale12(12'hf00);
      2'd1:    c = scale12(12'hf8b);
      2'd2:    c = scale12(12'hfa0);
      default: c = custom;
    endcase
    return c;
  endfunction

  logic [10:0]         x0_q    [N_SPR];
  logic [10:0]         y0_q    [N_SPR];
  logic [N_SPR-1:0]    en_q;
  logic [N_SPR-1:0]    auto_q;
  logic [NF_LOG2-1:0]  fsel_q  [N_SPR];
  logic [NF_LOG2-1:0]  ani_q   [N_SPR];
  logic [1:0]          csel_q  [N_SPR];
  logic [3:0]          rate_q  [N_SPR];
  logic [3:0]          cnt_q   [N_SPR];
  logic [CD-1:0]       color_q [N_SPR];
  logic [10:0]         x_prev;

  logic [1:0]          mem     [N_SPR][DEPTH];
  logic [1:0]          code_q  [N_SPR];
  logic [CD-1:0]       body_q  [N_SPR];
  logic [N_SPR-1:0]    in_q;

  logic [AW-1:0]       reg_sh_c, ram_sh_c;
  logic [IW-1:0]       reg_spr_c, ram_spr_c;
  logic                reg_wr_c, ram_wr_c, frame_tick_c;
  logic [11:0]         xr_c    [N_SPR];
  logic [11:0]         yr_c    [N_SPR];
  logic [N_SPR-1:0]    in_c;
  logic [PW-1:0]       raddr_c [N_SPR];
  logic [CD-1:0]       rgb_c;
  logic                hit_c;
  logic                unused_bits;

  assign unused_bits  = ^wr_data;
  assign reg_sh_c     = wr_addr >> 2;
  assign ram_sh_c     = wr_addr >> PW;
  assign reg_spr_c    = IW'(reg_sh_c) & IW'(N_SPR - 1);
  assign ram_spr_c    = IW'(ram_sh_c) & IW'(N_SPR - 1);
  assign reg_wr_c     = wr_en && !wr_ram;
  assign ram_wr_c     = wr_en && wr_ram && !reset;
  assign frame_tick_c = (x_prev == 11'd0) && (x == 11'd1) && (y == 11'd0);

  // Register file and animation dividers; a CTRL write restarts the divider
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(N_SPR); i++) begin
        x0_q[i]    <= '0;
        y0_q[i]    <= '0;
        fsel_q[i]  <= '0;
        ani_q[i]   <= '0;
        csel_q[i]  <= '0;
        rate_q[i]  <= '0;
        cnt_q[i]   <= '0;
        color_q[i] <= '0;
      end
      en_q   <= '0;
      auto_q <= '0;
      x_prev <= '0;
      in_q   <= '0;
    end else begin
      x_prev <= x;
      in_q   <= in_c;
      for (int i = 0; i < int'(N_SPR); i++) begin
        if (reg_wr_c && reg_spr_c == IW'(i)) begin
          case (wr_addr[1:0])
            2'd0: begin
              x0_q[i] <= wr_data[10:0];
              y0_q[i] <= wr_data[26:16];
            end
            2'd1: begin
              en_q[i]   <= wr_data[0];
              auto_q[i] <= wr_data[1];
              fsel_q[i] <= wr_data[NF_LOG2+1:2];
              csel_q[i] <= wr_data[9:8];
              rate_q[i] <= wr_data[15:12];
            end
            2'd2:    color_q[i] <= wr_data[CD-1:0];
            default: ;
          endcase
        end
        if (reg_wr_c && reg_spr_c == IW'(i) && wr_addr[1:0] == 2'd1) begin
          cnt_q[i] <= '0;
          ani_q[i] <= '0;
        end else if (frame_tick_c) begin
          if (cnt_q[i] == rate_q[i]) begin
            cnt_q[i] <= '0;
            ani_q[i] <= ani_q[i] + 1'b1;
          end else begin
            cnt_q[i] <= cnt_q[i] + 4'd1;
          end
        end
      end
    end
  end

  // Stage 1 region test and read address; negative offsets set bit 11 and fail the range test
  always_comb begin
    for (int i = 0; i < int'(N_SPR); i++) begin
      xr_c[i]    = {1'b0, x} - {1'b0, x0_q[i]};
      yr_c[i]    = {1'b0, y} - {1'b0, y0_q[i]};
      in_c[i]    = en_q[i] && (xr_c[i][11:SZ_LOG2] == '0) && (yr_c[i][11:SZ_LOG2] == '0);
      raddr_c[i] = {(auto_q[i] ? ani_q[i] : fsel_q[i]),
                    yr_c[i][SZ_LOG2-1:0], xr_c[i][SZ_LOG2-1:0]};
    end
  end

  // Pattern RAMs (read-before-write) and stage-1 colour capture
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(N_SPR); i++) begin
      if (ram_wr_c && ram_spr_c == IW'(i)) mem[i][wr_addr[PW-1:0]] <= wr_data[1:0];
      code_q[i] <= mem[i][raddr_c[i]];
      body_q[i] <= body_color(csel_q[i], color_q[i]);
    end
  end

  // Stage 2 palette lookup; descending scan lets the lowest index win
  always_comb begin
    rgb_c = KEY_COLOR;
    hit_c = 1'b0;
    for (int i = int'(N_SPR) - 1; i >= 0; i--) begin
      if (in_q[i] && code_q[i] != 2'b00) begin
        hit_c = 1'b1;
        case (code_q[i])
          2'b01:   rgb_c = scale12(12'h111);
          2'b10:   rgb_c = body_q[i];
          default: rgb_c = scale12(12'hfff);
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sprite_rgb <= KEY_COLOR;
      hit        <= 1'b0;
    end else begin
      sprite_rgb <= rgb_c;
      hit        <= hit_c;
    end
  end

endmodule

// File: tb/tb_sprite_multi_src.sv
// Scoreboard bench for sprite_multi_src: a driver predicts each pixel from a
// behavioural model and queues it; a monitor compares when that pixel emerges.
module tb_sprite_multi_src;

  localparam logic [11:0] KEY = 12'h000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] x = '0, y = '0;
  logic        wr_en = 1'b0, wr_ram = 1'b0;
  logic [11:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [11:0] sprite_rgb;
  logic        hit;

  sprite_multi_src dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .wr_en(wr_en), .wr_ram(wr_ram),
    .wr_addr(wr_addr), .wr_data(wr_data), .sprite_rgb(sprite_rgb), .hit(hit)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [11:0] rgb;
    logic        hit;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  // Model state: ticks counts frame ticks since the last CTRL write or reset
  int mx0[4], my0[4], mfsel[4], mcsel[4], mrate[4], mcolor[4], mticks[4];
  bit men[4], mauto[4];
  int pat[4][4][16][16];
  int xprev = 0;

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      mx0[i] = 0; my0[i] = 0; mfsel[i] = 0; mcsel[i] = 0; mrate[i] = 0;
      mcolor[i] = 0; mticks[i] = 0; men[i] = 0; mauto[i] = 0;
    end
    xprev = 0;
  endfunction

  function automatic logic [11:0] body(int s);
    case (mcsel[s])
      0:       return 12'hf00;
      1:       return 12'hf8b;
      2:       return 12'hfa0;
      default: return 12'(mcolor[s]);
    endcase
  endfunction

  function automatic exp_t model_pixel(int px, int py);
    exp_t e;
    e.due = 0; e.rgb = KEY; e.hit = 1'b0;
    for (int s = 0; s < 4; s++) begin
      int xr, yr, f, c;
      xr = px - mx0[s];
      yr = py - my0[s];
      if (men[s] && xr >= 0 && xr < 16 && yr >= 0 && yr < 16) begin
        f = mauto[s] ? (mticks[s] / (mrate[s] + 1)) % 4 : mfsel[s];
        c = pat[s][f][yr][xr];
        if (c != 0) begin
          e.hit = 1'b1;
          e.rgb = (c == 1) ? 12'h111 : (c == 2) ? body(s) : 12'hfff;
          return e;
        end
      end
    end
    return e;
  endfunction

  function automatic void apply_write(bit wram, int addr, logic [31:0] d);
    int s;
    if (wram) begin
      pat[(addr >> 10) & 3][(addr >> 8) & 3][(addr >> 4) & 15][addr & 15] = int'(d[1:0]);
    end else begin
      s = (addr >> 2) & 3;
      case (addr & 3)
        0: begin mx0[s] = int'(d[10:0]); my0[s] = int'(d[26:16]); end
        1: begin
          men[s] = d[0]; mauto[s] = d[1]; mfsel[s] = int'(d[3:2]);
          mcsel[s] = int'(d[9:8]); mrate[s] = int'(d[15:12]); mticks[s] = 0;
        end
        2: mcolor[s] = int'(d[11:0]);
        default: ;
      endcase
    end
  endfunction

  task automatic step(input int px, input int py, input bit we, input bit wram,
                      input int addr, input logic [31:0] d, input bit rst);
    exp_t e, t;
    bit   tick;
    @(negedge clk);
    x = 11'(px); y = 11'(py); wr_en = we; wr_ram = wram;
    wr_addr = 12'(addr); wr_data = d; reset = rst;
    if (rst) begin
      if (q.size() > 0 && q[q.size()-1].due == cyc + 1) begin
        t = q.pop_back();
        t.rgb = KEY; t.hit = 1'b0;
        q.push_back(t);
      end
      e.rgb = KEY; e.hit = 1'b0;
    end else begin
      e = model_pixel(px, py);
    end
    e.due = cyc + 2;
    q.push_back(e);
    tick = (xprev == 0 && px == 1 && py == 0);
    if (rst) model_reset();
    else begin
      if (tick) for (int i = 0; i < 4; i++) mticks[i]++;
      if (we) apply_write(wram, addr, d);
      xprev = px;
    end
  endtask

  task automatic pix(input int px, input int py);
    step(px, py, 1'b0, 1'b0, 0, 32'h0, 1'b0);
  endtask

  task automatic wreg(input int s, input int r, input logic [31:0] d);
    step(1000, 500, 1'b1, 1'b0, (s << 2) | r, d, 1'b0);
  endtask

  task automatic wram(input int s, input int f, input int r, input int c, input int code);
    step(1000, 500, 1'b1, 1'b1, (s << 10) | (f << 8) | (r << 4) | c, 32'(code), 1'b0);
  endtask

  task automatic tick();
    pix(0, 0);
    pix(1, 0);
  endtask

  // Monitor: compare every prediction whose due cycle has arrived
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        n_vec++;
        if (e.due != cyc || sprite_rgb !== e.rgb || hit !== e.hit) begin
          n_bad++;
          $display("FAIL pixel cyc=%0d due=%0d rgb=%h exp=%h hit=%b exp=%b",
                   cyc, e.due, sprite_rgb, e.rgb, hit, e.hit);
        end
      end
    end
  end

  initial begin
    logic [31:0] d;
    model_reset();
    for (int i = 0; i < 3; i++) step(100, 50, 1'b1, 1'b0, 4, 32'hffff_ffff, 1'b1);
    pix(100, 50);

    // Known contents everywhere before any sprite is enabled
    for (int s = 0; s < 4; s++)
      for (int f = 0; f < 4; f++)
        for (int r = 0; r < 16; r++)
          for (int c = 0; c < 16; c++)
            wram(s, f, r, c, int'($urandom_range(0, 3)));

    // Solid body-coloured sprite 0 with edge scans
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) wram(0, 0, r, c, 2);
    wreg(0, 0, {5'd0, 11'd50, 5'd0, 11'd100});
    wreg(0, 1, 32'h1);
    pix(100, 50); pix(116, 50); pix(115, 65); pix(99, 50); pix(100, 66);

    // Overlap: transparent lower index lets sprite 1 through, then opaque lower index wins
    wreg(1, 0, {5'd0, 11'd50, 5'd0, 11'd100});
    wreg(1, 1, 32'h1);
    wram(1, 0, 0, 0, 3);
    wram(0, 0, 0, 0, 0);
    pix(100, 50);
    step(100, 50, 1'b1, 1'b1, 0, 32'h1, 1'b0);
    pix(100, 50); pix(100, 50);
    wreg(1, 1, 32'h0);

    // Animation: one distinct pixel code per frame, rate 2
    for (int f = 0; f < 4; f++) wram(2, f, 0, 0, (f + 1) % 4);
    wreg(2, 0, {5'd0, 11'd60, 5'd0, 11'd300});
    wreg(2, 1, 32'h2003);
    pix(300, 60);
    for (int t = 0; t < 9; t++) begin tick(); pix(300, 60); end
    // CTRL write coincident with the tick that would wrap the divider
    tick(); pix(300, 60);
    tick(); pix(300, 60);
    pix(0, 0);
    step(1, 0, 1'b1, 1'b0, (2 << 2) | 1, 32'h2003, 1'b0);
    pix(300, 60);
    for (int t = 0; t < 4; t++) begin tick(); pix(300, 60); end

    // Right-edge clipping: a wrapped coordinate would land on column 8
    wram(3, 0, 0, 7, 3);
    wram(3, 0, 0, 8, 3);
    wreg(3, 0, {5'd0, 11'd70, 5'd0, 11'd2040});
    wreg(3, 1, 32'h1);
    pix(2047, 70); pix(0, 70); pix(2040, 70); pix(2039, 70);

    // Randomised registers, RAM writes and scans around a shared area
    for (int n = 0; n < 3000; n++) begin
      if (n % 25 == 0) tick();
      case ($urandom_range(0, 9))
        0: begin
          d = $urandom;
          d[10:0] = 11'(200 + $urandom_range(0, 30));
          d[26:16] = 11'(100 + $urandom_range(0, 20));
          step(int'($urandom_range(195, 250)), int'($urandom_range(95, 140)), 1'b1, 1'b0,
               int'($urandom_range(0, 15)) & ~3 | 0, d, 1'b0);
        end
        1: begin
          d = $urandom;
          d[0] = ($urandom_range(0, 3) != 0);
          d[15:12] = 4'($urandom_range(0, 3));
          step(int'($urandom_range(195, 250)), int'($urandom_range(95, 140)), 1'b1, 1'b0,
               (int'($urandom_range(0, 1023)) << 2) | 1, d, 1'b0);
        end
        2: step(int'($urandom_range(195, 250)), int'($urandom_range(95, 140)), 1'b1, 1'b0,
                int'($urandom_range(0, 4095)), $urandom, 1'b0);
        3: step(int'($urandom_range(195, 250)), int'($urandom_range(95, 140)), 1'b1, 1'b1,
                int'($urandom_range(0, 4095)), $urandom, 1'b0);
        default: step(int'($urandom_range(195, 250)), int'($urandom_range(95, 140)), 1'b0,
                      1'($urandom_range(0, 1)), int'($urandom_range(0, 4095)), $urandom, 1'b0);
      endcase
    end

    // Reset while a sprite is visible; registers come back disabled
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) wram(0, 0, r, c, 3);
    wreg(0, 0, {5'd0, 11'd50, 5'd0, 11'd100});
    wreg(0, 1, 32'h1);
    pix(100, 50); pix(101, 51);
    step(100, 50, 1'b1, 1'b0, 1, 32'h1, 1'b1);
    pix(100, 50); pix(102, 52); pix(100, 50);
    wreg(0, 1, 32'h1);
    pix(100, 50);
    for (int i = 0; i < 4; i++) pix(1000, 500);

    repeat (4) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sprite_multi_src.md
SPRITE_MULTI_SRC -- requirements
Module: sprite_multi_src

Interface
REQ-001 The block SHALL have parameter CD, default 12, meaning colour depth in bits.
REQ-002 The block SHALL have parameter N_SPR, default 4, meaning sprite channel count (power of two, 1..8).
REQ-003 The block SHALL have parameter SZ_LOG2, default 4, meaning log2 of the square sprite edge (16 px).
REQ-004 The block SHALL have parameter NF_LOG2, default 2, meaning log2 of animation frames per sprite.
REQ-005 The block SHALL have parameter KEY_COLOR, default 0, meaning chroma-key colour, also output when no sprite is hit.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-008 The block SHALL have ports x and y, input, 11 bits each: current scan coordinate.
REQ-009 The block SHALL have port wr_en, input, 1 bit: write strobe, one write per cycle.
REQ-010 The block SHALL have port wr_ram, input, 1 bit: 1 = pattern RAM write, 0 = register write.
REQ-011 The block SHALL have port wr_addr, input, AW = clog2(N_SPR)+NF_LOG2+2*SZ_LOG2 bits.
REQ-012 The block SHALL have port wr_data, input, 32 bits: write data.
REQ-013 The block SHALL have port sprite_rgb, output, CD bits: composited pixel.
REQ-014 The block SHALL have port hit, output, 1 bit: 1 when sprite_rgb comes from a visible sprite pixel.

Function
REQ-015 RAM write: wr_addr = {idx, frame, row, col}; writes wr_data[1:0] to sprite idx's pattern RAM; there is one RAM per sprite, with synchronous read.
REQ-016 Register write: wr_addr[1:0] selects the register and wr_addr[clog2(N_SPR)+1:2] selects the sprite; upper bits are ignored.
REQ-017 Register 0 is ORIGIN: x0 = wr_data[10:0], y0 = wr_data[26:16].
REQ-018 Register 1 is CTRL: en = [0], auto = [1], fsel = [NF_LOG2+1:2], csel = [9:8], rate = [15:12].
REQ-019 Register 2 is COLOR: custom colour = wr_data[CD-1:0]; register 3 is reserved, writes are ignored.
REQ-020 Region per sprite: xr = x-x0 and yr = y-y0, signed 12-bit; in region iff 0 <= xr,yr < 2**SZ_LOG2 and en = 1.
REQ-021 Read address per sprite: {frame_id, yr[SZ_LOG2-1:0], xr[SZ_LOG2-1:0]}; frame_id = ani counter when auto = 1, else fsel.
REQ-022 Palette per sprite: 00 = transparent; 01 = 12'h111; 10 = body colour; 11 = 12'hfff, with colours scaled to CD by MSB alignment.
REQ-023 Body colour by csel: 00 red f00; 01 pink f8b; 10 orange fa0; 11 COLOR register.
REQ-024 Priority: the lowest-index sprite that is in region with a non-transparent code wins; with no winner, sprite_rgb = KEY_COLOR and hit = 0.
REQ-025 Pipeline: stage 1 registers in-region flags and issues RAM reads; stage 2 registers the palette/priority result; latency is exactly 2 clocks from x/y to sprite_rgb/hit.
REQ-026 frame_tick is 1 for one cycle when x_prev == 0, x == 1 and y == 0; x_prev is x delayed one clock.
REQ-027 Per-sprite divider cnt: on frame_tick, if cnt == rate then cnt <= 0 and ani <= ani+1 (wrapping at 2**NF_LOG2), else cnt <= cnt+1.
REQ-028 rate = 0 SHALL advance ani every frame_tick.
REQ-029 A CTRL write SHALL clear that sprite's cnt and ani in the same cycle, taking precedence over a simultaneous frame_tick.
REQ-030 Register writes take effect for pixels entering stage 1 on the next cycle; a RAM write and a read of the same address in one cycle returns old data.
REQ-031 Coordinates near the edge: x0 + size beyond 2047 SHALL clip (signed compare), with no wrap to x = 0.

Reset
REQ-032 On reset, all en, auto, fsel, csel, rate, cnt, ani, x0, y0, COLOR and x_prev SHALL be 0.
REQ-033 On reset, pipeline registers SHALL clear: sprite_rgb = KEY_COLOR and hit = 0 on the cycle after reset is sampled high.
REQ-034 Pattern RAM contents SHALL NOT be reset.
REQ-035 Reset mid-frame SHALL abort animation and drop in-flight pixels; writes coincident with reset are ignored.

Verification
REQ-036 Fill sprite 0 frame 0 with code 10, set ORIGIN = (100,50), CTRL en = 1, csel = 00; scan (100,50) -> f00 with hit = 1 two clocks later; (116,50) -> KEY_COLOR with hit = 0.
REQ-037 Overlap sprites 0 and 1 at the same origin, sprite 0 code 00 and sprite 1 code 11 at pixel (0,0) -> fff from sprite 1; set sprite 0 code 01 -> 111.
REQ-038 Set auto = 1, rate = 2 and issue 9 frame_ticks -> ani sequence 0,0,1,1,1,2,2,2,3 (advancing on ticks 3 and 6 and 9 after CTRL write).
REQ-039 Write CTRL on the same cycle as a frame_tick with cnt == rate -> cnt = 0 and ani = 0 afterwards.
REQ-040 Set ORIGIN x0 = 2040 and scan x = 2047 -> in region (xr = 7); scan x = 0 -> not in region.
REQ-041 Assert reset for 1 clock while a sprite is visible -> sprite_rgb = KEY_COLOR with hit = 0 next cycle; after release, registers read as disabled, so the sprite stays invisible until rewritten.
